// File: rtl/gates_selftest_ctrl.sv
// gates_selftest_ctrl
//   Self-test sequencer for the two-input gates block. It applies the four
//   a/b combinations in order 00,10,01,11 (a,b), holding each one for DWELL
//   cycles. It samples the six gate results at the end of each dwell and
//   accumulates mismatch statistics.
//
// Ports
//   clk, rst_n        clock (rising edge) and async active-low reset
//   start             run request, honoured only in IDLE
//   a, b              stimulus driven into the gates block
//   andout..xnorout   gate results under test
//   busy              high while vectors are applied (4*DWELL cycles)
//   done              one-cycle pulse when a run completes
//   pass              last run had no mismatches; held until next start
//   err_cnt           saturating count of mismatching result bits
//   err_vec           bit i set if vector i had any mismatch

// One checker lane per gate output: flags a result bit that differs from
// the truth-table value.
module gates_selftest_lane (
    input  logic obs,
    input  logic exp,
    output logic miss
);
    assign miss = obs ^ exp;
endmodule

module gates_selftest_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             andout,
    input  logic             orout,
    input  logic             xorout,
    input  logic             nandout,
    input  logic             norout,
    input  logic             xnorout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       err_vec
);
    // DWELL=0 is meaningless; run it as a single-cycle dwell.
    localparam int DW = (DWELL < 1) ? 1 : DWELL;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int NUM_LANES = 6;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic [NUM_LANES-1:0] obs, exp, miss;
    logic [2:0]           mism;
    logic [CNT_W+2:0]     sum;
    logic [CNT_W-1:0]     err_nxt;
    logic                 accept, sample, finish;

    // Lane order: and, or, xor, nand, nor, xnor (bit 0 upward).
    assign obs = {xnorout, norout, nandout, xorout, orout, andout};
    assign exp = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        gates_selftest_lane u_lane (
            .obs  (obs[l]),
            .exp  (exp[l]),
            .miss (miss[l])
        );
    end

    always_comb begin
        mism = '0;
        for (int i = 0; i < NUM_LANES; i++)
            mism = mism + {2'b00, miss[i]};
    end

    // Three guard bits absorb up to +6 so the clamp test cannot wrap.
    always_comb begin
        sum     = {3'b000, err_cnt} + (CNT_W+3)'(mism);
        err_nxt = (|sum[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST && idx == 2'd3) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decoded from state
    always_comb begin
        accept = (state == S_IDLE) && start;
        sample = (state == S_RUN) && (cnt == CNT_LAST);
        finish = sample && (idx == 2'd3);
    end

    // Stimulus and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            err_vec <= '0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy    <= 1'b1;
                {b, a}  <= 2'b00;
                idx     <= '0;
                cnt     <= '0;
                err_cnt <= '0;
                err_vec <= '0;
                pass    <= 1'b0;
            end else if (state == S_RUN) begin
                if (!sample) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt          <= '0;
                    err_cnt      <= err_nxt;
                    err_vec[idx] <= (mism != 3'd0);
                    if (!finish) begin
                        idx    <= idx + 2'd1;
                        {b, a} <= idx + 2'd1;
                    end else begin
                        // Fold in the vector being sampled on this edge.
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= (err_vec == 4'b0000) && (mism == 3'd0);
                        {b, a} <= 2'b00;
                        idx    <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gates_selftest_ctrl.sv
// Bench for gates_selftest_ctrl: three instances (DWELL=4/CNT_W=8,
// DWELL=4/CNT_W=4, DWELL=1/CNT_W=8), each driving its own gates model
// with a selectable fault. Expected run results go into a queue when a
// run is started and are popped when the DUT pulses done.
module tb_gates_selftest_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      start = '0;
    logic [2:0]      a_w, b_w, busy_w, done_w, pass_w;
    logic [2:0][7:0] errc_w;
    logic [2:0][3:0] errv_w;
    logic [3:0]      errc_sat;
    logic [2:0][5:0] gout;
    logic [1:0]      fault = 2'd0;

    typedef struct {
        logic [7:0] errc;
        logic [3:0] errv;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;

    // Gate outputs, bit order and,or,xor,nand,nor,xnor.
    // f=1: xorout stuck at 0, f=2: every output inverted.
    function automatic logic [5:0] gate_model(input logic ga, input logic gb, input logic [1:0] f);
        logic [5:0] g;
        g = {~(ga ^ gb), ~(ga | gb), ~(ga & gb), ga ^ gb, ga | gb, ga & gb};
        case (f)
            2'd1:    g[2] = 1'b0;
            2'd2:    g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    function automatic exp_t predict(input logic [1:0] f, input int maxc);
        exp_t       e;
        int         c;
        int         m;
        logic [1:0] v2;
        c = 0;
        e.errv = '0;
        for (int v = 0; v < 4; v++) begin
            v2 = 2'(v);
            m = $countones(gate_model(v2[0], v2[1], 2'd0) ^ gate_model(v2[0], v2[1], f));
            c = c + m;
            if (c > maxc) c = maxc;
            e.errv[v] = (m != 0);
        end
        e.errc = 8'(c);
        e.pass = (e.errv == 4'b0000);
        return e;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_model
        assign gout[k] = gate_model(a_w[k], b_w[k], fault);
    end

    gates_selftest_ctrl #(.DWELL(4), .CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_w[0]), .b(b_w[0]),
        .andout(gout[0][0]), .orout(gout[0][1]), .xorout(gout[0][2]),
        .nandout(gout[0][3]), .norout(gout[0][4]), .xnorout(gout[0][5]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(errc_w[0]), .err_vec(errv_w[0])
    );

    gates_selftest_ctrl #(.DWELL(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_w[1]), .b(b_w[1]),
        .andout(gout[1][0]), .orout(gout[1][1]), .xorout(gout[1][2]),
        .nandout(gout[1][3]), .norout(gout[1][4]), .xnorout(gout[1][5]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(errc_sat), .err_vec(errv_w[1])
    );
    assign errc_w[1] = {4'b0000, errc_sat};

    gates_selftest_ctrl #(.DWELL(1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_w[2]), .b(b_w[2]),
        .andout(gout[2][0]), .orout(gout[2][1]), .xorout(gout[2][2]),
        .nandout(gout[2][3]), .norout(gout[2][4]), .xnorout(gout[2][5]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_cnt(errc_w[2]), .err_vec(errv_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input int k, input string tag);
        chk({tag, ".a"},    a_w[k],    0);
        chk({tag, ".b"},    b_w[k],    0);
        chk({tag, ".busy"}, busy_w[k], 0);
        chk({tag, ".done"}, done_w[k], 0);
        chk({tag, ".pass"}, pass_w[k], 0);
        chk({tag, ".errc"}, errc_w[k], 0);
        chk({tag, ".errv"}, errv_w[k], 0);
    endtask

    // One full run on instance k. With poke set, start is also pulsed in
    // mid-run and during DONE; both must be ignored.
    task automatic run(input int k, input int dw, input int maxc,
                       input logic [1:0] f, input bit poke, input string tag);
        exp_t e;
        int   nbusy;
        int   badab;
        int   cyc;
        int   idx;
        fault = f;
        sb.push_back(predict(f, maxc));
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
        chk({tag, ".acc_busy"}, busy_w[k], 1);
        chk({tag, ".acc_errc"}, errc_w[k], 0);
        chk({tag, ".acc_errv"}, errv_w[k], 0);
        chk({tag, ".acc_pass"}, pass_w[k], 0);
        nbusy = 0; badab = 0; cyc = 0;
        while (!done_w[k] && cyc < 200) begin
            if (busy_w[k]) begin
                idx = nbusy / dw;
                if ({b_w[k], a_w[k]} !== 2'(idx)) badab++;
                nbusy++;
            end
            start[k] = poke && (nbusy == 5);
            @(negedge clk);
            cyc++;
        end
        start[k] = 1'b0;
        chk({tag, ".done_seen"}, done_w[k], 1);
        chk({tag, ".busy_len"}, nbusy, 4 * dw);
        chk({tag, ".ab_seq_bad"}, badab, 0);
        chk({tag, ".busy_at_done"}, busy_w[k], 0);
        chk({tag, ".ab_at_done"}, {b_w[k], a_w[k]}, 0);
        if (sb.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL %s.sb_empty: observed 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".errc"}, errc_w[k], e.errc);
            chk({tag, ".errv"}, errv_w[k], e.errv);
            chk({tag, ".pass"}, pass_w[k], e.pass);
            start[k] = poke;
            @(negedge clk); start[k] = 1'b0;
            chk({tag, ".done_1cyc"}, done_w[k], 0);
            chk({tag, ".no_restart"}, busy_w[k], 0);
            @(negedge clk);
            chk({tag, ".hold_errc"}, errc_w[k], e.errc);
            chk({tag, ".hold_pass"}, pass_w[k], e.pass);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_zero(0, "rst0");
        chk_idle_zero(1, "rst1");
        chk_idle_zero(2, "rst2");
        rst_n = 1'b1;

        run(0, 4, 255, 2'd0, 1'b0, "t1_good");
        run(0, 4, 255, 2'd1, 1'b0, "t2_xor_sa0");
        run(0, 4, 255, 2'd2, 1'b0, "t3_inv");
        run(1, 4, 15,  2'd2, 1'b0, "t3_inv_sat");
        run(0, 4, 255, 2'd2, 1'b1, "t4_poke_bad");
        run(0, 4, 255, 2'd0, 1'b1, "t4_poke_good");

        // Reset in the middle of a failing run
        fault = 2'd2;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5.pre_errc", errc_w[0], 6);
        chk("t5.pre_busy", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero(0, "t5.rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5.no_done", done_w[0], 0);
        end
        rst_n = 1'b1;
        run(0, 4, 255, 2'd0, 1'b0, "t5_rerun");

        run(2, 1, 255, 2'd0, 1'b0, "t6_d1_good");
        run(2, 1, 255, 2'd1, 1'b0, "t6_d1_xor");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/gates_selftest_ctrl.md
Name: gates_selftest_ctrl

Overview:
Self-test sequencer wrapped around the two-input gates block (AND/OR/XOR/NAND/NOR/XNOR). It drives the gate inputs a/b through the four input combinations and holds each one for a programmable dwell. At the end of each dwell it samples the six gate outputs and compares them against the expected truth table. It accumulates mismatch statistics and reports pass/fail with a done pulse, acting as both the upstream stimulus stage and the downstream checker for the gates block.

Parameters:
DWELL, 4, cycles each input vector is held before its outputs are sampled; legal range >= 1.
CNT_W, 8, width of the error counter; the counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  run request; sampled only in IDLE
a  output  1  gate input a
b  output  1  gate input b
andout  input  1  gate result a&b
orout  input  1  gate result a|b
xorout  input  1  gate result a^b
nandout  input  1  gate result ~(a&b)
norout  input  1  gate result ~(a|b)
xnorout  input  1  gate result ~(a^b)
busy  output  1  high while vectors are being applied
done  output  1  one-cycle pulse at end of run
pass  output  1  1 when the last completed run had zero mismatches; held until next start
err_cnt  output  CNT_W  total mismatching output bits in the last or current run, saturating
err_vec  output  4  bit i set if vector i had any mismatch

Behaviour:
- Reset: rst_n is asynchronous and active-low; one clock, clk. While rst_n is low: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, err_vec=0, idx=0, dwell counter=0.
- Reset mid-run aborts the run immediately. No done pulse is produced, and results are cleared.
- Vector order is idx 0..3, with a=idx[0] and b=idx[1]: 00, 10, 01, 11 (a,b).
- States:
  - IDLE: start=1 at an edge moves to RUN. On the same edge: busy<=1, a/b<=vector 0, cnt<=0, err_cnt<=0, err_vec<=0, pass<=0.
  - RUN, cnt!=DWELL-1: cnt<=cnt+1; a/b hold.
  - RUN, cnt==DWELL-1: compare the six inputs against expected values computed from the current a/b. mism = popcount of mismatching bits (0..6). err_cnt<=min(err_cnt+mism, 2^CNT_W-1). err_vec[idx]<=(mism!=0). cnt<=0.
    - If idx<3: idx<=idx+1 and a/b<=next vector.
    - If idx==3: go to DONE. busy<=0, done<=1, pass<=(final err_vec==0, including the current vector), a<=0, b<=0, idx<=0.
  - DONE: lasts one cycle. done<=0, then return to IDLE.
- Timing: busy is high for exactly 4*DWELL cycles. Each vector is stable for DWELL cycles, and the sample is taken at the edge ending the last dwell cycle.
- The gates block is purely combinational, so DWELL=1 is legal. DWELL=0 is illegal and the implementation treats it as 1.
- start is ignored in RUN and DONE. A start held high continuously begins a new run on the first IDLE edge after DONE.
- err_cnt, err_vec and pass remain stable from DONE until the next accepted start.
- Simultaneous saturation and increment: err_cnt clamps and never wraps.
- The dwell counter width is clog2(DWELL) with a minimum of 1 bit.

Test Plan:
1. Correct gates model, DWELL=4, 1-cycle start pulse -> busy=1 for 16 cycles. a,b = 00,10,01,11, each held 4 cycles. done pulses once. pass=1, err_cnt=0, err_vec=4'b0000.
2. xorout stuck-at-0 -> mismatches at vectors 1 and 2 only. err_cnt=2, err_vec=4'b0110, pass=0.
3. All six outputs inverted, CNT_W=8 -> err_cnt=24, err_vec=4'b1111, pass=0. Same fault with CNT_W=4 -> err_cnt saturates at 15.
4. start pulsed during busy and during DONE -> ignored, and run length stays 16 cycles. start after DONE -> err_cnt, err_vec and pass clear on the accept edge, and the second run repeats scenario 1 results.
5. rst_n driven low in cycle 6 of a run -> a, b, busy and err_* go to 0 immediately, with no done pulse. A start after release runs a full fresh sequence with pass=1.
6. DWELL=1, correct model -> busy high for exactly 4 cycles with a new vector every cycle. done one cycle after the last vector; pass=1.
